alu_biquad_cascade: RTL
=======================

# alu_biquad_cascade

Time-multiplexed, multi-channel cascade of second-order IIR sections with saturating fixed-point arithmetic. It is the parametrised successor of the single-section, single-channel filter ALU. One multiply-accumulate datapath serves `N_STAGES` cascaded biquads for each of `N_CH` independent channels, with per-channel, per-stage history registers. It sits between the voice/mixer sample sources and the output DAC path.

## Interface
- `DATA_W`, 18: sample width, signed two's complement.
- `COEF_W`, 18: coefficient width, signed.
- `FRAC_BITS`, 16: fractional bits of the coefficients (Q2.16 at default).
- `N_STAGES`, 2: cascaded biquad sections, 1..8.
- `N_CH`, 2: independent channels, 1..16. `CH_W = max(1, clog2(N_CH))`.
- `clk`  in  1  clock; all logic on the rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `coefs_flat`  in  `N_STAGES*5*COEF_W`  coefficients. Stage s, term k sits at `[(5*s+k)*COEF_W +: COEF_W]`. Order of k: b0, b1, b2, a1, a2. Feedback terms are added, so the caller pre-negates them. Shared by all channels. Must be stable while `busy`.
- `sample_in`  in  `DATA_W`  input sample.
- `sample_in_ch`  in  `CH_W`  channel of `sample_in`.
- `sample_in_rdy`  in  1  single-cycle strobe; `sample_in` is valid.
- `flush`  in  1  clears all history of all channels.
- `busy`  out  1  high whenever the FSM is not in IDLE.
- `sample_out`  out  `DATA_W`  filtered sample; 0 when `sample_out_rdy` is low.
- `sample_out_ch`  out  `CH_W`  channel of `sample_out`.
- `sample_out_rdy`  out  1  single-cycle strobe.
- `overflow`  out  1  valid with `sample_out_rdy`: some stage saturated for this sample.
- `overrun`  out  1  sticky: an input strobe was dropped. Cleared only by reset.

## Operation
- FSM states: IDLE, CALC, WAIT, WRITE, DONE.
- IDLE:
  - `flush` = 1: zero all history registers in one cycle, stay in IDLE. `flush` has priority over `sample_in_rdy`; a sample presented in that cycle is dropped without setting `overrun`.
  - `sample_in_rdy` = 1 with `sample_in_ch < N_CH`: latch sample and channel, set stage = 0, clear accumulator, go to CALC.
  - `sample_in_ch >= N_CH`: strobe ignored silently.
- CALC, 5 cycles, term k = 0..4:
  - Multiplier operands are coef[s][k] × {x0, x1, x2, y1, y2}[ch][s].
  - x0 is the stage input: the latched sample for s = 0, the previous stage's result otherwise.
- Multiplier pipeline: the product is registered and the accumulator adds it one cycle later. WAIT lasts 2 cycles to drain the pipeline.
- WRITE (stages not last) or DONE (last stage):
  - Result = accumulator arithmetically shifted right by `FRAC_BITS`, truncated toward −inf.
  - The result saturates to [−2^(DATA_W−1), 2^(DATA_W−1)−1]; saturation sets the per-sample overflow flag.
  - History update: x2←x1, x1←x0, y2←y1, y1←result (saturated value).
  - The accumulator clears and the stage increments.
  - WRITE returns to CALC. DONE drives outputs and returns to IDLE.
- Accumulator width is `DATA_W+COEF_W+4` and must not wrap for any 5-term sum.
- Channels never share history. Coefficients are shared by all channels.
- `sample_in_rdy` while `busy`: sample dropped, `overrun` set, calculation unaffected.

## Timing
- Strobe accepted on edge E0. CALC occupies the cycles after E0+0..4, WAIT E0+5..6, WRITE/DONE E0+7.
- Each stage takes 8 cycles. `sample_out_rdy` is high for exactly one cycle, ending at edge E0+8·`N_STAGES` (16 cycles at default).
- `busy` rises the cycle after E0 and falls with the DONE→IDLE transition.
- A new sample can be accepted on the first IDLE cycle. Maximum rate is one sample per 8·`N_STAGES`+1 cycles.
- Reset values: `busy`, `sample_out`, `sample_out_ch`, `sample_out_rdy`, `overflow` and `overrun` are all 0. FSM returns to IDLE, all history is zeroed, accumulator cleared.
- Reset in mid-operation aborts the sample immediately, with no output strobe.

## Test plan
- Passthrough, default params, b0 = 0x10000 (1.0) for both stages, other coefficients 0. Input 0x01000 on ch0 → `sample_out` 0x01000, ch0, 16 cycles after accept, `overflow` 0.
- Recursion: stage 0 b0 = 0x10000 and a1 = 0x08000 (0.5); stage 1 passthrough. Impulse 0x10000 on ch0, then zeros → outputs 0x10000, 0x08000, 0x04000, 0x02000.
- Isolation: interleave the ch0 impulse sequence above with ch1 zeros → ch1 always 0, ch0 sequence identical to the previous test.
- Saturation: stage 0 b0 = 0x18000 (1.5). Input 0x1FFFF → output 0x1FFFF with `overflow` 1. Input 0x20000 → output 0x20000 with `overflow` 1.
- Drop and flush:
  - Strobe at cycle E0+3 → ignored, `overrun` 1, output identical to the run with no extra strobe.
  - `flush` in IDLE after an impulse → next zero input gives output 0.
- Reset mid-CALC: `reset_n` low for 1 cycle at E0+2 → no output strobe, all outputs 0. Repeating the recursion test afterwards gives the fresh-state sequence.

Source files
------------

// File: rtl/alu_biquad_cascade.sv
// Time-multiplexed cascade of biquad sections shared by several channels.
// One multiplier and one accumulator walk through five terms per stage;
// each channel keeps its own x1/x2/y1/y2 history for every stage.
module alu_biquad_cascade #(
  parameter  int DATA_W    = 18,
  parameter  int COEF_W    = 18,
  parameter  int FRAC_BITS = 16,
  parameter  int N_STAGES  = 2,
  parameter  int N_CH      = 2,
  localparam int CH_W      = (N_CH > 1) ? $clog2(N_CH) : 1
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [N_STAGES*5*COEF_W-1:0] coefs_flat,
  input  logic [DATA_W-1:0]            sample_in,
  input  logic [CH_W-1:0]              sample_in_ch,
  input  logic                         sample_in_rdy,
  input  logic                         flush,
  output logic                         busy,
  output logic [DATA_W-1:0]            sample_out,
  output logic [CH_W-1:0]              sample_out_ch,
  output logic                         sample_out_rdy,
  output logic                         overflow,
  output logic                         overrun
);

  localparam int ST_W   = (N_STAGES > 1) ? $clog2(N_STAGES) : 1;
  localparam int PROD_W = DATA_W + COEF_W;
  localparam int ACC_W  = DATA_W + COEF_W + 4;

  typedef enum logic [2:0] {IDLE, CALC, WAIT, WRITE, DONE} state_t;

  state_t                     state_q, state_d;
  logic [2:0]                 k_q, k_d;
  logic [ST_W-1:0]            stage_q, stage_d;
  logic [CH_W-1:0]            ch_q, ch_d;
  logic signed [DATA_W-1:0]   stageIn_q, stageIn_d;
  logic signed [ACC_W-1:0]    acc_q, acc_d;
  logic                       ovf_q, ovf_d;
  logic signed [PROD_W-1:0]   prod_q;
  logic                       prodValid_q;
  logic                       overrun_q;

  logic signed [DATA_W-1:0]   x1_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]   x2_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]   y1_q [N_CH][N_STAGES];
  logic signed [DATA_W-1:0]   y2_q [N_CH][N_STAGES];

  logic signed [COEF_W-1:0]   coef [N_STAGES][5];
  logic signed [DATA_W-1:0]   mulOp;
  logic signed [PROD_W-1:0]   product;
  logic signed [ACC_W-1:0]    prodExt;
  logic signed [ACC_W-1:0]    shifted;
  logic [ACC_W-DATA_W:0]      shiftedHi;
  logic                       satNow;
  logic signed [DATA_W-1:0]   result;
  logic                       chOk;
  logic                       histWrite;
  logic                       flushHist;

  // Unpack the flat coefficient bus into a [stage][term] table.
  for (genvar s = 0; s < N_STAGES; s++) begin : gStage
    for (genvar t = 0; t < 5; t++) begin : gTerm
      assign coef[s][t] = coefs_flat[(5*s+t)*COEF_W +: COEF_W];
    end
  end

  assign chOk = 32'(sample_in_ch) < N_CH;

  // Pick the history operand for the current term and form the product.
  always_comb begin
    mulOp = stageIn_q;
    case (k_q)
      3'd1:    mulOp = x1_q[ch_q][stage_q];
      3'd2:    mulOp = x2_q[ch_q][stage_q];
      3'd3:    mulOp = y1_q[ch_q][stage_q];
      3'd4:    mulOp = y2_q[ch_q][stage_q];
      default: mulOp = stageIn_q;
    endcase
    product = mulOp * coef[stage_q][k_q];
  end

  // Scale the finished sum back to sample format, flooring and saturating.
  always_comb begin
    prodExt   = {{(ACC_W-PROD_W){prod_q[PROD_W-1]}}, prod_q};
    shifted   = acc_q >>> FRAC_BITS;
    shiftedHi = shifted[ACC_W-1:DATA_W-1];
    satNow    = !((&shiftedHi) || (~|shiftedHi));
    if (satNow)
      result = shifted[ACC_W-1] ? {1'b1, {(DATA_W-1){1'b0}}} : {1'b0, {(DATA_W-1){1'b1}}};
    else
      result = shifted[DATA_W-1:0];
  end

  // Sequencer: accept, five MAC terms, pipeline drain, then write-back.
  always_comb begin
    state_d   = state_q;
    k_d       = k_q;
    stage_d   = stage_q;
    ch_d      = ch_q;
    stageIn_d = stageIn_q;
    acc_d     = prodValid_q ? acc_q + prodExt : acc_q;
    ovf_d     = ovf_q;
    histWrite = 1'b0;
    flushHist = 1'b0;
    case (state_q)
      IDLE: begin
        if (flush) begin
          flushHist = 1'b1;
        end else if (sample_in_rdy && chOk) begin
          state_d   = CALC;
          k_d       = 3'd0;
          stage_d   = '0;
          ch_d      = sample_in_ch;
          stageIn_d = $signed(sample_in);
          acc_d     = '0;
          ovf_d     = 1'b0;
        end
      end
      CALC: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd4) begin
          state_d = WAIT;
          k_d     = 3'd0;
        end
      end
      WAIT: begin
        k_d = k_q + 3'd1;
        if (k_q == 3'd1) begin
          state_d = (stage_q == ST_W'(N_STAGES-1)) ? DONE : WRITE;
          k_d     = 3'd0;
        end
      end
      WRITE: begin
        histWrite = 1'b1;
        acc_d     = '0;
        stage_d   = stage_q + ST_W'(1);
        stageIn_d = result;
        ovf_d     = ovf_q | satNow;
        state_d   = CALC;
        k_d       = 3'd0;
      end
      DONE: begin
        histWrite = 1'b1;
        acc_d     = '0;
        stage_d   = '0;
        state_d   = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Sequencer and accumulator registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      k_q       <= '0;
      stage_q   <= '0;
      ch_q      <= '0;
      stageIn_q <= '0;
      acc_q     <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      k_q       <= k_d;
      stage_q   <= stage_d;
      ch_q      <= ch_d;
      stageIn_q <= stageIn_d;
      acc_q     <= acc_d;
      ovf_q     <= ovf_d;
    end
  end

  // Registered multiplier output; valid one cycle after each CALC term.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      prod_q      <= '0;
      prodValid_q <= 1'b0;
    end else begin
      prod_q      <= product;
      prodValid_q <= (state_q == CALC);
    end
  end

  // Sticky flag for strobes that arrive while a sample is in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)
      overrun_q <= 1'b0;
    else if (state_q != IDLE && sample_in_rdy)
      overrun_q <= 1'b1;
  end

  // Per-channel, per-stage history: bulk clear or shift on write-back.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
    end else if (flushHist) begin
      for (int c = 0; c < N_CH; c++)
        for (int s = 0; s < N_STAGES; s++) begin
          x1_q[c][s] <= '0;
          x2_q[c][s] <= '0;
          y1_q[c][s] <= '0;
          y2_q[c][s] <= '0;
        end
    end else if (histWrite) begin
      x1_q[ch_q][stage_q] <= stageIn_q;
      x2_q[ch_q][stage_q] <= x1_q[ch_q][stage_q];
      y1_q[ch_q][stage_q] <= result;
      y2_q[ch_q][stage_q] <= y1_q[ch_q][stage_q];
    end
  end

  assign busy           = (state_q != IDLE);
  assign sample_out_rdy = (state_q == DONE);
  assign sample_out     = (state_q == DONE) ? result : '0;
  assign sample_out_ch  = (state_q == DONE) ? ch_q : '0;
  assign overflow       = (state_q == DONE) && (ovf_q || satNow);
  assign overrun        = overrun_q;

endmodule
